// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer for a MIPS-style datapath: walks each instruction
// through FETCH/EXEC/MEM/WB and decodes the datapath selects from the latched word.
module datapath_sequencer (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] imemload,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        zero,
  output logic        iREN,
  output logic        dREN,
  output logic        dWEN,
  output logic        pc_en,
  output logic        reg_wen,
  output logic        link_sel,
  output logic [1:0]  pc_sel,
  output logic [1:0]  mem_to_reg_sel,
  output logic        alu_src_sel,
  output logic        reg_dst_sel,
  output logic        halt,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    MEM   = 3'd2,
    WB    = 3'd3,
    HALT  = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] PC_JUMP   = 2'd0;
  localparam logic [1:0] PC_JR     = 2'd1;
  localparam logic [1:0] PC_NEXT   = 2'd2;
  localparam logic [1:0] PC_BRANCH = 2'd3;

  localparam logic [1:0] M2R_ALU   = 2'd0;
  localparam logic [1:0] M2R_NPC   = 2'd1;
  localparam logic [1:0] M2R_DLOAD = 2'd2;
  localparam logic [1:0] M2R_LUI   = 2'd3;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;
  logic        iren_q, iren_d;
  logic        dren_q, dren_d;
  logic        dwen_q, dwen_d;
  logic        pc_en_q, pc_en_d;
  logic        reg_wen_q, reg_wen_d;
  logic        halt_q, halt_d;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        dec_write;
  logic        dec_lw;
  logic        dec_sw;
  logic [1:0]  dec_pc_sel;
  logic [1:0]  dec_m2r;
  logic        dec_alu_src;
  logic        dec_reg_dst;
  logic        dec_link;

  assign opcode = ir_q[31:26];
  assign funct  = ir_q[5:0];

  // Instruction decode, purely a function of the latched ir (and zero for branches).
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    dec_write   = 1'b0;
    dec_lw      = 1'b0;
    dec_sw      = 1'b0;
    dec_pc_sel  = PC_NEXT;
    dec_m2r     = M2R_ALU;
    dec_alu_src = 1'b0;
    dec_reg_dst = 1'b0;
    dec_link    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          dec_pc_sel = PC_JR;
        end else begin
          dec_write = 1'b1;
        end
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
        dec_write   = 1'b1;
        dec_reg_dst = 1'b1;
        dec_alu_src = 1'b1;
      end
      OP_LUI: begin
        dec_write   = 1'b1;
        dec_reg_dst = 1'b1;
        dec_m2r     = M2R_LUI;
      end
      OP_LW: begin
        dec_lw      = 1'b1;
        dec_write   = 1'b1;
        dec_reg_dst = 1'b1;
        dec_alu_src = 1'b1;
        dec_m2r     = M2R_DLOAD;
      end
      OP_SW: begin
        dec_sw      = 1'b1;
        dec_alu_src = 1'b1;
      end
      OP_J: begin
        dec_pc_sel = PC_JUMP;
      end
      OP_JAL: begin
        dec_write  = 1'b1;
        dec_pc_sel = PC_JUMP;
        dec_m2r    = M2R_NPC;
        dec_link   = 1'b1;
      end
      OP_BEQ: begin
        dec_pc_sel = zero ? PC_BRANCH : PC_NEXT;
      end
      OP_BNE: begin
        dec_pc_sel = zero ? PC_NEXT : PC_BRANCH;
      end
      default: begin
        // Unlisted opcodes (including HALT, which never reaches WB) act as NOP.
      end
    endcase
  end

  // Next-state logic; strobes are precomputed from the next state so they come
  // straight out of flops in the cycle the FSM occupies that state.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      FETCH: begin
        if (ihit) begin
          ir_d    = imemload;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (opcode == OP_HALT) begin
          state_d = HALT;
        end else if (dec_lw || dec_sw) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (dhit) begin
          state_d = WB;
        end
      end
      WB: begin
        retired_d = retired_q + 32'd1;
        state_d   = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    iren_d    = (state_d == FETCH);
    dren_d    = (state_d == MEM) && dec_lw;
    dwen_d    = (state_d == MEM) && dec_sw;
    pc_en_d   = (state_d == WB);
    reg_wen_d = (state_d == WB) && dec_write;
    halt_d    = (state_d == HALT);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      retired_q <= '0;
      iren_q    <= 1'b0;
      dren_q    <= 1'b0;
      dwen_q    <= 1'b0;
      pc_en_q   <= 1'b0;
      reg_wen_q <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values of the others, independent of statement order.
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      iren_q    <= iren_d;
      dren_q    <= dren_d;
      dwen_q    <= dwen_d;
      pc_en_q   <= pc_en_d;
      reg_wen_q <= reg_wen_d;
      halt_q    <= halt_d;
    end
  end

  assign iREN           = iren_q;
  assign dREN           = dren_q;
  assign dWEN           = dwen_q;
  assign pc_en          = pc_en_q;
  assign reg_wen        = reg_wen_q;
  assign halt           = halt_q;
  assign retired        = retired_q;
  assign pc_sel         = dec_pc_sel;
  assign mem_to_reg_sel = dec_m2r;
  assign alu_src_sel    = dec_alu_src;
  assign reg_dst_sel    = dec_reg_dst;
  assign link_sel       = dec_link;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scenario-driven bench for datapath_sequencer: expected WB records go into a
// scoreboard queue as instructions are issued and are compared when pc_en fires.
module tb_datapath_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] imemload;
  logic        ihit, dhit, zero;
  logic        iREN, dREN, dWEN, pc_en, reg_wen, link_sel;
  logic [1:0]  pc_sel, mem_to_reg_sel;
  logic        alu_src_sel, reg_dst_sel, halt;
  logic [31:0] retired;

  always #5 CLK = ~CLK;

  datapath_sequencer dut (
    .CLK(CLK), .nRST(nRST), .imemload(imemload), .ihit(ihit), .dhit(dhit),
    .zero(zero), .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .pc_en(pc_en),
    .reg_wen(reg_wen), .link_sel(link_sel), .pc_sel(pc_sel),
    .mem_to_reg_sel(mem_to_reg_sel), .alu_src_sel(alu_src_sel),
    .reg_dst_sel(reg_dst_sel), .halt(halt), .retired(retired)
  );

  localparam logic [31:0] I_ADDI  = 32'h2000_0005;
  localparam logic [31:0] I_RTYPE = 32'h0000_0020;
  localparam logic [31:0] I_JR    = 32'h03E0_0008;
  localparam logic [31:0] I_LUI   = 32'h3C01_1234;
  localparam logic [31:0] I_LW    = 32'h8C22_0004;
  localparam logic [31:0] I_SW    = 32'hAC22_0008;
  localparam logic [31:0] I_BEQ   = 32'h1022_0003;
  localparam logic [31:0] I_BNE   = 32'h1422_0003;
  localparam logic [31:0] I_J     = 32'h0800_0010;
  localparam logic [31:0] I_JAL   = 32'h0C00_0010;
  localparam logic [31:0] I_UNK   = 32'hF800_0000;
  localparam logic [31:0] I_HALT  = 32'hFC00_0000;

  typedef struct {
    int         fetch;
    int         dren;
    int         dwen;
    logic       wen;
    logic [1:0] pc;
    logic [1:0] m2r;
    logic       alu;
    logic       rdst;
    logic       link;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_retired = '0;

  task automatic push_exp(input int fetch, input int dr, input int dw, input logic wen,
                          input logic [1:0] pc, input logic [1:0] m2r, input logic alu,
                          input logic rdst, input logic link);
    exp_t e;
    e.fetch = fetch; e.dren = dr; e.dwen = dw; e.wen = wen; e.pc = pc;
    e.m2r = m2r; e.alu = alu; e.rdst = rdst; e.link = link;
    sb.push_back(e);
  endtask

  // Watches every cycle, counts request cycles per instruction and compares the
  // WB cycle against the oldest expected record.
  task automatic monitor();
    int f = 0, r = 0, w = 0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        f = 0; r = 0; w = 0;
        exp_retired = '0;
      end else begin
        if (iREN) f++;
        if (dREN) r++;
        if (dWEN) w++;
        if (pc_en) begin
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL wb_unexpected: got a WB cycle, want none");
          end else begin
            e = sb.pop_front();
            n_checks++; if (f !== e.fetch) begin n_fail++; $display("FAIL wb_fetch_cycles: got %0d want %0d", f, e.fetch); end
            n_checks++; if (r !== e.dren) begin n_fail++; $display("FAIL wb_dren_cycles: got %0d want %0d", r, e.dren); end
            n_checks++; if (w !== e.dwen) begin n_fail++; $display("FAIL wb_dwen_cycles: got %0d want %0d", w, e.dwen); end
            n_checks++; if (reg_wen !== e.wen) begin n_fail++; $display("FAIL wb_reg_wen: got %0b want %0b", reg_wen, e.wen); end
            n_checks++; if (pc_sel !== e.pc) begin n_fail++; $display("FAIL wb_pc_sel: got %0d want %0d", pc_sel, e.pc); end
            n_checks++; if (mem_to_reg_sel !== e.m2r) begin n_fail++; $display("FAIL wb_mem_to_reg: got %0d want %0d", mem_to_reg_sel, e.m2r); end
            n_checks++; if (alu_src_sel !== e.alu) begin n_fail++; $display("FAIL wb_alu_src: got %0b want %0b", alu_src_sel, e.alu); end
            n_checks++; if (reg_dst_sel !== e.rdst) begin n_fail++; $display("FAIL wb_reg_dst: got %0b want %0b", reg_dst_sel, e.rdst); end
            n_checks++; if (link_sel !== e.link) begin n_fail++; $display("FAIL wb_link_sel: got %0b want %0b", link_sel, e.link); end
            n_checks++; if (retired !== exp_retired) begin n_fail++; $display("FAIL wb_retired: got %0d want %0d", retired, exp_retired); end
            exp_retired = exp_retired + 32'd1;
          end
          f = 0; r = 0; w = 0;
        end
      end
    end
  endtask

  // Issues one instruction with the given memory latencies; returns the number
  // of strobe-free (EXEC) cycles seen and retired one edge after WB.
  task automatic drive_instr(input logic [31:0] instr, input int ihit_dly, input int dhit_dly,
                             input logic z, output int exec_n, output logic [31:0] ret_after,
                             output logic saw_halt);
    int fetch_n = 0;
    int mem_n = 0;
    bit done = 0;
    exec_n = 0; ret_after = '0; saw_halt = 1'b0;
    imemload = instr; zero = z;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge CLK);
      ihit = 1'b0; dhit = 1'b0;
      if (halt) begin
        saw_halt = 1'b1; done = 1;
      end else if (pc_en) begin
        @(posedge CLK); #1;
        ret_after = retired; done = 1;
      end else if (iREN) begin
        fetch_n++;
        ihit = (fetch_n == ihit_dly + 1);
      end else if (dREN || dWEN) begin
        mem_n++;
        dhit = (mem_n == dhit_dly + 1);
      end else begin
        exec_n++;
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL instr_timeout: instr %h got no WB/HALT within 200 cycles", instr);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; imemload = '0; ihit = 1'b0; dhit = 1'b0; zero = 1'b0;
    #12;
    n_checks++; if ({iREN, dREN, dWEN, pc_en, reg_wen} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want 00000", {iREN, dREN, dWEN, pc_en, reg_wen}); end
    n_checks++; if (halt !== 1'b0 || retired !== 32'd0) begin n_fail++; $display("FAIL reset_halt_retired: got %b/%0d want 0/0", halt, retired); end
    n_checks++; if (pc_sel !== 2'd2) begin n_fail++; $display("FAIL reset_pc_sel: got %0d want 2", pc_sel); end
    n_checks++; if ({mem_to_reg_sel, alu_src_sel, reg_dst_sel, link_sel} !== 5'b0) begin n_fail++; $display("FAIL reset_selects: got %b want 00000", {mem_to_reg_sel, alu_src_sel, reg_dst_sel, link_sel}); end
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    n_checks++; if (iREN !== 1'b1) begin n_fail++; $display("FAIL reset_release_iren: got %b want 1", iREN); end
  endtask

  task automatic test_addi();
    int ex; logic [31:0] ra; logic hs;
    push_exp(4, 0, 0, 1'b1, 2'd2, 2'd0, 1'b1, 1'b1, 1'b0);
    drive_instr(I_ADDI, 3, 0, 1'b0, ex, ra, hs);
    n_checks++; if (ex !== 1) begin n_fail++; $display("FAIL addi_exec_cycles: got %0d want 1", ex); end
    n_checks++; if (ra !== 32'd1) begin n_fail++; $display("FAIL addi_retired: got %0d want 1", ra); end
  endtask

  task automatic test_load_store();
    int ex; logic [31:0] ra; logic hs;
    push_exp(1, 3, 0, 1'b1, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0);
    drive_instr(I_LW, 0, 2, 1'b0, ex, ra, hs);
    n_checks++; if (ex !== 1 || ra !== 32'd2) begin n_fail++; $display("FAIL lw_exec_retired: got %0d/%0d want 1/2", ex, ra); end
    push_exp(2, 0, 2, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0);
    drive_instr(I_SW, 1, 1, 1'b0, ex, ra, hs);
    n_checks++; if (ex !== 1 || ra !== 32'd3) begin n_fail++; $display("FAIL sw_exec_retired: got %0d/%0d want 1/3", ex, ra); end
  endtask

  task automatic test_branch();
    int ex; logic [31:0] ra; logic hs;
    logic [31:0] instr [4] = '{I_BEQ, I_BEQ, I_BNE, I_BNE};
    logic        z     [4] = '{1'b1,  1'b0,  1'b0,  1'b1};
    logic [1:0]  pc    [4] = '{2'd3,  2'd2,  2'd3,  2'd2};
    for (int i = 0; i < 4; i++) begin
      push_exp(i % 3 + 1, 0, 0, 1'b0, pc[i], 2'd0, 1'b0, 1'b0, 1'b0);
      drive_instr(instr[i], i % 3, 0, z[i], ex, ra, hs);
      n_checks++; if (ra !== 32'(4 + i)) begin n_fail++; $display("FAIL branch%0d_retired: got %0d want %0d", i, ra, 4 + i); end
    end
  endtask

  task automatic test_jump_and_misc();
    int ex; logic [31:0] ra; logic hs;
    push_exp(1, 0, 0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1); drive_instr(I_JAL,   0, 0, 1'b0, ex, ra, hs);
    push_exp(1, 0, 0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0); drive_instr(I_JR,    0, 0, 1'b0, ex, ra, hs);
    push_exp(1, 0, 0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0); drive_instr(I_J,     0, 0, 1'b0, ex, ra, hs);
    push_exp(1, 0, 0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0); drive_instr(I_RTYPE, 0, 0, 1'b0, ex, ra, hs);
    push_exp(1, 0, 0, 1'b1, 2'd2, 2'd3, 1'b0, 1'b1, 1'b0); drive_instr(I_LUI,   0, 0, 1'b0, ex, ra, hs);
    push_exp(1, 0, 0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0); drive_instr(I_UNK,   0, 0, 1'b1, ex, ra, hs);
    n_checks++; if (ex !== 1 || ra !== 32'd13) begin n_fail++; $display("FAIL nop_exec_retired: got %0d/%0d want 1/13", ex, ra); end
  endtask

  task automatic test_reset_mid_mem();
    bit seen = 0;
    int bad = 0;
    imemload = I_LW; zero = 1'b0;
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      @(negedge CLK);
      ihit = iREN; dhit = 1'b0;
      seen = dREN;
    end
    ihit = 1'b0;
    n_checks++; if (!seen) begin n_fail++; $display("FAIL midmem_reach_mem: got no dREN, want dREN within 50 cycles"); end
    @(negedge CLK); #2;
    nRST = 1'b0;
    #1;
    n_checks++; if ({dREN, dWEN, pc_en, reg_wen, iREN} !== 5'b0) begin n_fail++; $display("FAIL midmem_strobes_drop: got %b want 00000", {dREN, dWEN, pc_en, reg_wen, iREN}); end
    n_checks++; if (retired !== 32'd0 || pc_sel !== 2'd2) begin n_fail++; $display("FAIL midmem_retired_pc_sel: got %0d/%0d want 0/2", retired, pc_sel); end
    repeat (3) begin
      @(negedge CLK);
      if (pc_en || reg_wen) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL midmem_no_wb: got %0d WB cycles want 0", bad); end
    nRST = 1'b1;
    @(posedge CLK); #1;
    n_checks++; if (iREN !== 1'b1 || retired !== 32'd0) begin n_fail++; $display("FAIL midmem_release: got iREN=%b retired=%0d want 1/0", iREN, retired); end
  endtask

  task automatic test_halt();
    int ex; logic [31:0] ra; logic hs;
    push_exp(1, 0, 0, 1'b1, 2'd2, 2'd0, 1'b1, 1'b1, 1'b0); drive_instr(I_ADDI,  0, 0, 1'b0, ex, ra, hs);
    push_exp(1, 0, 0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0); drive_instr(I_RTYPE, 0, 0, 1'b0, ex, ra, hs);
    push_exp(1, 0, 0, 1'b1, 2'd2, 2'd3, 1'b0, 1'b1, 1'b0); drive_instr(I_LUI,   0, 0, 1'b0, ex, ra, hs);
    push_exp(1, 0, 1, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0); drive_instr(I_SW,    0, 0, 1'b0, ex, ra, hs);
    push_exp(1, 0, 0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0); drive_instr(I_UNK,   0, 0, 1'b0, ex, ra, hs);
    n_checks++; if (ra !== 32'd5) begin n_fail++; $display("FAIL halt_pre_retired: got %0d want 5", ra); end
    drive_instr(I_HALT, 0, 0, 1'b0, ex, ra, hs);
    n_checks++; if (hs !== 1'b1 || ex !== 1) begin n_fail++; $display("FAIL halt_entry: got halt=%b exec=%0d want 1/1", hs, ex); end
    for (int c = 0; c < 20; c++) begin
      ihit = c[0]; dhit = ~c[0];
      @(negedge CLK);
      n_checks++;
      if ({iREN, dREN, dWEN, pc_en, reg_wen} !== 5'b0 || halt !== 1'b1 || retired !== 32'd5) begin
        n_fail++;
        $display("FAIL halt_hold_c%0d: got strobes=%b halt=%b retired=%0d want 00000/1/5", c, {iREN, dREN, dWEN, pc_en, reg_wen}, halt, retired);
      end
    end
    ihit = 1'b0; dhit = 1'b0;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_addi();
    test_load_store();
    test_branch();
    test_jump_and_misc();
    test_reset_mid_mem();
    test_halt();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
